// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - trace capture buffer: arm, record observed bytes, stop or fill, drain oldest-first; optional CAPTURE_DEDUP_EN suppresses repeated records
module trace_capture #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic [5:0]               x_obs,
  input  logic                     stbi_obs,
  input  logic                     obs_flag,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           r_ovf;
  logic [7:0]     r_rd_data;
  logic           r_rd_valid;
  logic [7:0]     r_mem [DEPTH];

  logic [7:0]     w_rec;
  logic           w_new;
  logic           w_last_slot;
  logic           w_start;
  logic           w_wr;
  logic           w_fill;
  logic           w_pop;

  assign w_rec       = {obs_flag, stbi_obs, x_obs};
  // The write that lands in the last free slot is the one that fills the buffer.
  assign w_last_slot = (r_count == (AW+1)'(DEPTH - 1));

`ifdef CAPTURE_DEDUP_EN
  logic [7:0] r_last;
  logic       r_have_last;

  assign w_new = !r_have_last || (w_rec != r_last);

  // Remember the most recent record written in this capture for duplicate suppression.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last      <= 8'h00;
      r_have_last <= 1'b0;
    end else if (w_start) begin
      r_have_last <= 1'b0;
    end else if (w_wr) begin
      r_last      <= w_rec;
      r_have_last <= 1'b1;
    end
  end
`else
  assign w_new = 1'b1;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle control strobes; stop has priority over a filling write.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_wr    = 1'b0;
    w_fill  = 1'b0;
    w_pop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          w_start = 1'b1;
          w_next  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (stop) begin
          w_next = ST_DONE;
        end else if (w_new) begin
          w_wr = 1'b1;
          if (w_last_slot) begin
            w_fill = 1'b1;
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (r_count == '0) begin
          w_next = ST_IDLE;
        end else if (rd_en) begin
          w_pop = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Pointers, occupancy, overflow flag and registered read port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_start) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end
      if (w_wr) begin
        r_wptr  <= r_wptr + AW'(1);
        r_count <= r_count + (AW+1)'(1);
      end
      if (w_fill) begin
        r_ovf <= 1'b1;
      end
      if (w_pop) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + AW'(1);
        r_count   <= r_count - (AW+1)'(1);
      end
    end
  end

  // Trace storage; contents are irrelevant after reset so it carries no reset.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_rec;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign count    = r_count;
  assign state    = r_state;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - scoreboard bench for trace_capture against a queue-based reference model
module tb_trace_capture;

  localparam int DEPTH = 16;
  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_DONE = 2;

  logic       clock;
  logic       reset;
  logic       arm;
  logic       stop;
  logic [5:0] x_obs;
  logic       stbi_obs;
  logic       obs_flag;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic [1:0] state;
  logic       ovf;

  trace_capture #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .arm      (arm),
    .stop     (stop),
    .x_obs    (x_obs),
    .stbi_obs (stbi_obs),
    .obs_flag (obs_flag),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .state    (state),
    .ovf      (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         vectors = 0;
  int         miscompares = 0;
  int         n_valid = 0;
  logic [7:0] last_rd = 8'h00;

  // Reference model: stored records as a queue, expected pops as a scoreboard queue.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_state = M_IDLE;
  logic       m_ovf = 1'b0;
  logic       m_have = 1'b0;
  logic [7:0] m_last = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding expected record.
  always @(negedge clock) begin
    if (!reset) begin
      if (rd_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        end else begin
          chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        last_rd = rd_data;
      end else if (rd_data !== last_rd) begin
        chk("rd_data_hold", 32'(rd_data), 32'(last_rd));
      end
    end
  end

  task automatic cycle(input logic a, input logic s, input logic [7:0] rec, input logic r);
    logic wr;
    arm = a;
    stop = s;
    {obs_flag, stbi_obs, x_obs} = rec;
    rd_en = r;
    case (m_state)
      M_IDLE: begin
        if (a) begin
          m_q.delete();
          m_ovf = 1'b0;
          m_have = 1'b0;
          m_state = M_CAP;
        end
      end
      M_CAP: begin
        if (s) begin
          m_state = M_DONE;
        end else begin
          wr = 1'b1;
`ifdef CAPTURE_DEDUP_EN
          wr = !m_have || (rec != m_last);
`endif
          if (wr) begin
            m_q.push_back(rec);
            m_last = rec;
            m_have = 1'b1;
            if (m_q.size() == DEPTH) begin
              m_state = M_DONE;
              m_ovf = 1'b1;
            end
          end
        end
      end
      default: begin
        if (m_q.size() == 0) m_state = M_IDLE;
        else if (r) exp_q.push_back(m_q.pop_front());
      end
    endcase
    @(posedge clock);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("count", 32'(count), 32'(m_q.size()));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    #3;
    m_q.delete();
    exp_q.delete();
    m_state = M_IDLE;
    m_ovf = 1'b0;
    m_have = 1'b0;
    last_rd = 8'h00;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 8 && m_state != M_IDLE; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_to_idle", 32'(state), 32'd0);
  endtask

  initial begin
    int nv;
    logic [7:0] rec;
    reset = 1'b1;
    arm = 1'b0; stop = 1'b0; x_obs = '0; stbi_obs = 1'b0; obs_flag = 1'b0; rd_en = 1'b0;
    do_reset();

    // Three records then stop, drained in order.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h41, 1'b0);
    cycle(1'b0, 1'b0, 8'h05, 1'b0);
    cycle(1'b0, 1'b0, 8'hBF, 1'b0);
    cycle(1'b0, 1'b1, 8'hFF, 1'b0);
    chk("t31_count", 32'(count), 32'd3);
    chk("t31_state", 32'(state), 32'd2);
    chk("t31_ovf", 32'(ovf), 32'd0);
    drain();

    // Fill without stop: 16 writes, overflow, 17th record dropped.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, 8'(i * 7 + 1), 1'b0);
    chk("t32_count", 32'(count), 32'd16);
    chk("t32_ovf", 32'(ovf), 32'd1);
    chk("t32_state", 32'(state), 32'd2);
    drain();
    chk("t32_ovf_sticky", 32'(ovf), 32'd1);

    // Reset mid-drain discards everything; new capture starts from slot 0.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'(8'hA0 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h5A, 1'b0);
    cycle(1'b0, 1'b0, 8'hC3, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t33_count", 32'(count), 32'd2);
    drain();

    // rd_en held 5 cycles with two stored; arm during DONE ignored.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h11, 1'b0);
    cycle(1'b0, 1'b0, 8'h22, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    nv = n_valid;
    for (int i = 0; i < 5; i++) cycle(i < 3, 1'b0, 8'h00, 1'b1);
    chk("t34_pulses", 32'(n_valid - nv), 32'd2);
    chk("t34_state", 32'(state), 32'd0);

    // Duplicate sequence.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h12, 1'b0);
    cycle(1'b0, 1'b0, 8'h12, 1'b0);
    cycle(1'b0, 1'b0, 8'h12, 1'b0);
    cycle(1'b0, 1'b0, 8'h13, 1'b0);
    cycle(1'b0, 1'b0, 8'h12, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
`ifdef CAPTURE_DEDUP_EN
    chk("t35_count", 32'(count), 32'd3);
`else
    chk("t35_count", 32'(count), 32'd5);
`endif
    drain();

    // arm with stop from IDLE, then stop in first capture cycle.
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    chk("t36_cap", 32'(state), 32'd1);
    cycle(1'b0, 1'b1, 8'h77, 1'b0);
    chk("t36_done", 32'(state), 32'd2);
    chk("t36_count", 32'(count), 32'd0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t36_idle", 32'(state), 32'd0);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        rec = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        cycle($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0, rec, $urandom_range(0, 1) == 1);
      end
    end
    drain();
    @(negedge clock);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
